// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam logic        UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with registered occupancy and registered ready flag.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_c,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     ready_o,
    output logic                     empty_c,
    output logic                     empty_nxt_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             ready_q, ready_d;
    logic             full_c;
    logic             push_ok_c;
    logic             pop_ok_c;

    assign full_c      = (level_q == LVL_W'(DEPTH));
    assign empty_c     = (level_q == '0);
    assign empty_nxt_c = (level_d == '0);
    assign push_ok_c   = push_i && !full_c;
    assign pop_ok_c    = pop_i && !empty_c;
    assign head_c      = mem_q[rd_ptr_q];
    assign level_o     = level_q;
    assign ready_o     = ready_q;

    // Pointer, occupancy and ready next-state; pointers wrap on the power-of-two depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok_c) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok_c) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok_c, pop_ok_c})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        ready_d = (level_d < LVL_W'(DEPTH));
    end

    // Control registers; reset flushes the FIFO by clearing pointers and level.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ready_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ready_q  <= ready_d;
        end
    end

    // Storage array; contents need no reset since the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (push_ok_c) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1/8E1 UART transmitter: byte FIFO feeding a bit-serialising FSM.
module uart_tx_buffered #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter bit          PARITY_EN  = 1'b0,
    parameter int unsigned DIV_WIDTH  = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [7:0]                    tx_data_i,
    input  logic                          tx_valid_i,
    output logic                          tx_ready_o,
    input  logic [DIV_WIDTH-1:0]          cfg_div_i,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    import uart_pkg::*;

    localparam int unsigned IDX_W = $clog2(UART_DATA_BITS);

    uart_tx_state_e              state_q, state_d;
    logic [DIV_WIDTH-1:0]        cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0]        period_q, period_d;
    logic [IDX_W-1:0]            bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0]   shift_q, shift_d;
    logic                        parity_q, parity_d;
    logic                        tx_q, tx_d;
    logic                        busy_q, busy_d;

    logic                        pop_c;
    logic [UART_DATA_BITS-1:0]   head_c;
    logic                        empty_c;
    logic                        empty_nxt_c;
    logic [DIV_WIDTH-1:0]        div_eff_c;

    // A zero divisor would stall the bit counter, so it is promoted to one clock per bit.
    assign div_eff_c = (cfg_div_i == '0) ? DIV_WIDTH'(1) : cfg_div_i;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (tx_valid_i),
        .data_i      (tx_data_i),
        .pop_i       (pop_c),
        .head_c      (head_c),
        .level_o     (fifo_level_o),
        .ready_o     (tx_ready_o),
        .empty_c     (empty_c),
        .empty_nxt_c (empty_nxt_c)
    );

    // Frame sequencing: each bit is held for period_q clocks via a reload-and-count-down counter.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        tx_d      = tx_q;
        pop_c     = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d = UART_IDLE_LEVEL;
                if (!empty_c) begin
                    pop_c     = 1'b1;
                    shift_d   = head_c;
                    period_d  = div_eff_c;
                    cnt_d     = div_eff_c - 1'b1;
                    bit_idx_d = '0;
                    parity_d  = 1'b0;
                    tx_d      = 1'b0;
                    state_d   = START;
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    cnt_d     = period_q - 1'b1;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                    parity_d  = shift_q[0];
                    state_d   = DATA;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    cnt_d = period_q - 1'b1;
                    if (bit_idx_q == IDX_W'(UART_DATA_BITS - 1)) begin
                        if (PARITY_EN) begin
                            tx_d    = parity_q;
                            state_d = PARITY;
                        end else begin
                            tx_d    = UART_IDLE_LEVEL;
                            state_d = STOP;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        tx_d      = shift_q[bit_idx_d];
                        parity_d  = parity_q ^ shift_q[bit_idx_d];
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            PARITY: begin
                if (cnt_q == '0) begin
                    cnt_d   = period_q - 1'b1;
                    tx_d    = UART_IDLE_LEVEL;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == '0) begin
                    if (!empty_c) begin
                        pop_c     = 1'b1;
                        shift_d   = head_c;
                        period_d  = div_eff_c;
                        cnt_d     = div_eff_c - 1'b1;
                        bit_idx_d = '0;
                        parity_d  = 1'b0;
                        tx_d      = 1'b0;
                        state_d   = START;
                    end else begin
                        tx_d    = UART_IDLE_LEVEL;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                tx_d    = UART_IDLE_LEVEL;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE) || !empty_nxt_c;
    end

    // State and datapath registers; reset aborts any frame and drives the line idle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            tx_q      <= UART_IDLE_LEVEL;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign tx_o   = tx_q;
    assign busy_o = busy_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: one 8N1 instance and one 8E1 instance.
module tb_uart_tx_buffered;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  d0, d1;
    logic        v0, v1;
    logic [15:0] div0, div1;
    logic        r0, r1, tx0, tx1, b0, b1;
    logic [3:0]  l0, l1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uart_tx_buffered #(.FIFO_DEPTH(8), .PARITY_EN(1'b0), .DIV_WIDTH(16)) u_dut (
        .clk_i(clk), .rst_i(rst), .tx_data_i(d0), .tx_valid_i(v0), .tx_ready_o(r0),
        .cfg_div_i(div0), .tx_o(tx0), .busy_o(b0), .fifo_level_o(l0)
    );

    uart_tx_buffered #(.FIFO_DEPTH(8), .PARITY_EN(1'b1), .DIV_WIDTH(16)) u_dut_par (
        .clk_i(clk), .rst_i(rst), .tx_data_i(d1), .tx_valid_i(v1), .tx_ready_o(r1),
        .cfg_div_i(div1), .tx_o(tx1), .busy_o(b1), .fifo_level_o(l1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic line(input int sel);
        return (sel != 0) ? tx1 : tx0;
    endfunction

    function automatic logic [10:0] frame_n(input logic [7:0] b);
        return {2'b01, b, 1'b0};
    endfunction

    function automatic logic [10:0] frame_p(input logic [7:0] b);
        return {1'b1, ^b, b, 1'b0};
    endfunction

    // Hold valid until the byte is taken; stall counts edges where ready was low.
    task automatic push_byte(input int sel, input logic [7:0] b, output int stall);
        logic rdy;
        logic done;
        stall = 0;
        done  = 1'b0;
        if (sel != 0) begin v1 = 1'b1; d1 = b; end
        else          begin v0 = 1'b1; d0 = b; end
        for (int i = 0; i < 1000 && !done; i++) begin
            rdy = (sel != 0) ? r1 : r0;
            @(posedge clk); #1;
            if (rdy) done = 1'b1;
            else     stall++;
        end
        if (!done) check("push_timeout", 32'd0, 32'd1);
    endtask

    // Wait for a start bit, then sample every clock of the frame.
    task automatic rx_frame(input int sel, input int p, input int nbits,
                            output logic [10:0] bits, output int waited, output logic stable);
        logic found;
        logic v;
        bits   = '0;
        stable = 1'b1;
        waited = 0;
        found  = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(posedge clk); #1;
            waited++;
            if (line(sel) == 1'b0) found = 1'b1;
        end
        if (!found) begin
            check("rx_start_timeout", 32'd0, 32'd1);
            return;
        end
        for (int k = 0; k < nbits * p; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            v = line(sel);
            if (k % p == 0) bits[k / p] = v;
            else if (v !== bits[k / p]) stable = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [10:0] bits;
        logic        stb;
        logic [7:0]  b;
        logic [7:0]  exp_q [$];
        int          w, st, p, lows;

        rst = 1'b1; v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0; div0 = 16'd4; div1 = 16'd3;
        repeat (3) step();
        check("rst_tx",    tx0, 1); check("rst_ready", r0, 1);
        check("rst_busy",  b0,  0); check("rst_level", l0, 0);
        check("rst_tx_p",  tx1, 1); check("rst_level_p", l1, 0);
        rst = 1'b0;
        step();

        // 1: single 0x55 at 4 clk/bit
        div0 = 16'd4;
        push_byte(0, 8'h55, st); v0 = 1'b0;
        check("t1_stall", st, 0);
        check("t1_busy_on", b0, 1);
        rx_frame(0, 4, 10, bits, w, stb);
        check("t1_latency", w, 1);
        check("t1_frame", bits, frame_n(8'h55));
        check("t1_stable", stb, 1);
        step();
        check("t1_idle_tx", tx0, 1);
        check("t1_busy_off", b0, 0);

        // 2: nine bytes back-to-back, tenth stalls until the first stop completes
        div0 = 16'd2;
        fork
            begin
                for (int i = 0; i < 9; i++) push_byte(0, 8'(8'h10 + i), st);
                check("t2_level_full", l0, 8);
                check("t2_ready_low", r0, 0);
                push_byte(0, 8'h19, st);
                v0 = 1'b0;
                check("t2_stall", st, 13);
            end
            begin
                for (int i = 0; i < 10; i++) begin
                    rx_frame(0, 2, 10, bits, w, stb);
                    check($sformatf("t2_frame%0d", i), bits, frame_n(8'(8'h10 + i)));
                    check($sformatf("t2_gap%0d", i), w, (i == 0) ? 2 : 1);
                    check($sformatf("t2_stable%0d", i), stb, 1);
                end
            end
        join
        step();
        check("t2_busy_off", b0, 0);
        check("t2_level_empty", l0, 0);

        // 3: even parity, 3 clk/bit
        div1 = 16'd3;
        push_byte(1, 8'h07, st); v1 = 1'b0;
        rx_frame(1, 3, 11, bits, w, stb);
        check("t3_latency_07", w, 1);
        check("t3_frame_07", bits, 11'b110_0000_1110);
        check("t3_stable_07", stb, 1);
        step();
        push_byte(1, 8'h03, st); v1 = 1'b0;
        rx_frame(1, 3, 11, bits, w, stb);
        check("t3_frame_03", bits, 11'b100_0000_0110);
        check("t3_stable_03", stb, 1);
        step();
        check("t3_busy_off", b1, 0);

        // 4: reset during data bit 3 aborts the frame and flushes the queue
        div0 = 16'd4;
        push_byte(0, 8'hA3, st);
        push_byte(0, 8'h11, st); v0 = 1'b0;
        check("t4_start", tx0, 0);
        repeat (17) step();
        check("t4_bit3", tx0, 0);
        check("t4_level_pre", l0, 1);
        rst = 1'b1;
        step();
        check("t4_rst_tx", tx0, 1);
        check("t4_rst_level", l0, 0);
        check("t4_rst_ready", r0, 1);
        check("t4_rst_busy", b0, 0);
        rst = 1'b0;
        step();
        push_byte(0, 8'h0A, st); v0 = 1'b0;
        rx_frame(0, 4, 10, bits, w, stb);
        check("t4_latency", w, 1);
        check("t4_frame", bits, frame_n(8'h0A));
        check("t4_stable", stb, 1);
        lows = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (tx0 == 1'b0) lows++;
        end
        check("t4_no_stale", lows, 0);
        check("t4_busy_off", b0, 0);

        // 5: divisor 0 acts as 1; a mid-frame divisor change applies to the next frame
        div0 = 16'd0;
        fork
            begin
                push_byte(0, 8'hFF, st);
                push_byte(0, 8'h5A, st); v0 = 1'b0;
                step();
                div0 = 16'd8;
            end
            begin
                rx_frame(0, 1, 10, bits, w, stb);
                check("t5_latency", w, 2);
                check("t5_frame_ff", bits, frame_n(8'hFF));
                rx_frame(0, 8, 10, bits, w, stb);
                check("t5_gap", w, 1);
                check("t5_frame_5a", bits, frame_n(8'h5A));
                check("t5_stable_5a", stb, 1);
            end
        join
        step();
        check("t5_busy_off", b0, 0);

        // 6: random single frames with random divisors and idle gaps
        for (int i = 0; i < 8; i++) begin
            p = $urandom_range(1, 16);
            b = 8'($urandom);
            div0 = 16'(p);
            repeat ($urandom_range(0, 4)) step();
            push_byte(0, b, st); v0 = 1'b0;
            rx_frame(0, p, 10, bits, w, stb);
            check($sformatf("t6_frame%0d", i), bits, frame_n(b));
            check($sformatf("t6_stable%0d", i), stb, 1);
        end

        // 6b: random burst checked in order against a queue
        p = $urandom_range(1, 16);
        div0 = 16'(p);
        for (int i = 0; i < 4; i++) exp_q.push_back(8'($urandom));
        fork
            begin
                for (int i = 0; i < 4; i++) push_byte(0, exp_q[i], st);
                v0 = 1'b0;
            end
            begin
                for (int i = 0; i < 4; i++) begin
                    rx_frame(0, p, 10, bits, w, stb);
                    b = exp_q.pop_front();
                    check($sformatf("t6b_frame%0d", i), bits, frame_n(b));
                    check($sformatf("t6b_stable%0d", i), stb, 1);
                    if (i > 0) check($sformatf("t6b_gap%0d", i), w, 1);
                end
            end
        join
        step();
        check("t6b_busy_off", b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
